// File: rtl/sap_sequencer.sv
// sap_sequencer: microcode sequencer for the 8-bit accumulator CPU.
// Steps T-states T0..T5 and decodes opcode/flags into a 16-bit control word.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   run        1 = free-run (one T-state per clock), 0 = single-step
//   step       single-step request; each 0->1 edge while run=0 advances once
//   opcode     IR[7:4], valid from T3 onward
//   flag_c     carry flag
//   flag_z     zero flag
//   out        control word {hlt, pc_inc, pc_en, pc_load, mar_load, mem_en,
//              mem_we, ir_load, ir_en, a_load, a_en, b_load, adder_sub,
//              adder_en, flags_load, out_load}
//   stage      current T-state 0..5
//   halted     1 while in HALT
//   instr_done 1-cycle pulse while executing an instruction's final T-state
module sap_sequencer #(
    parameter int unsigned EARLY_END = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] out,
    output logic [2:0]  stage,
    output logic        halted,
    output logic        instr_done
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } tstate_t;

    typedef enum logic [3:0] {
        OP_LDA = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_STA = 4'd3,
        OP_LDI = 4'd4,
        OP_JMP = 4'd5,
        OP_JC  = 4'd6,
        OP_JZ  = 4'd7,
        OP_OUT = 4'd14,
        OP_HLT = 4'd15
    } op_t;

    localparam logic [15:0] CW_HLT        = 16'h8000;
    localparam logic [15:0] CW_PC_INC     = 16'h4000;
    localparam logic [15:0] CW_PC_EN      = 16'h2000;
    localparam logic [15:0] CW_PC_LOAD    = 16'h1000;
    localparam logic [15:0] CW_MAR_LOAD   = 16'h0800;
    localparam logic [15:0] CW_MEM_EN     = 16'h0400;
    localparam logic [15:0] CW_MEM_WE     = 16'h0200;
    localparam logic [15:0] CW_IR_LOAD    = 16'h0100;
    localparam logic [15:0] CW_IR_EN      = 16'h0080;
    localparam logic [15:0] CW_A_LOAD     = 16'h0040;
    localparam logic [15:0] CW_A_EN       = 16'h0020;
    localparam logic [15:0] CW_B_LOAD     = 16'h0010;
    localparam logic [15:0] CW_ADDER_SUB  = 16'h0008;
    localparam logic [15:0] CW_ADDER_EN   = 16'h0004;
    localparam logic [15:0] CW_FLAGS_LOAD = 16'h0002;
    localparam logic [15:0] CW_OUT_LOAD   = 16'h0001;

    tstate_t     state;
    logic        halt_q;
    logic        step_q;
    logic        adv;
    logic        is_hlt;
    logic        last_early;
    logic        last;
    logic [15:0] word;

    assign stage  = state;
    assign halted = halt_q;
    assign adv    = !halt_q & (run | (step & !step_q));
    assign is_hlt = (state == T3) && (opcode == OP_HLT);

    // Microcode table; last_early marks the final useful T-state of each opcode.
    always_comb begin
        word       = '0;
        last_early = 1'b0;
        case (state)
            T0: word = CW_PC_EN | CW_MAR_LOAD;
            T1: word = CW_PC_INC;
            T2: word = CW_MEM_EN | CW_IR_LOAD;
            T3: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        word = CW_IR_EN | CW_MAR_LOAD;
                    OP_LDI: begin
                        word       = CW_IR_EN | CW_A_LOAD;
                        last_early = 1'b1;
                    end
                    OP_JMP: begin
                        word       = CW_IR_EN | CW_PC_LOAD;
                        last_early = 1'b1;
                    end
                    OP_JC: begin
                        if (flag_c)
                            word = CW_IR_EN | CW_PC_LOAD;
                        last_early = 1'b1;
                    end
                    OP_JZ: begin
                        if (flag_z)
                            word = CW_IR_EN | CW_PC_LOAD;
                        last_early = 1'b1;
                    end
                    OP_OUT: begin
                        word       = CW_A_EN | CW_OUT_LOAD;
                        last_early = 1'b1;
                    end
                    OP_HLT: begin
                        word       = CW_HLT;
                        last_early = 1'b1;
                    end
                    default: last_early = 1'b1;
                endcase
            end
            T4: begin
                case (opcode)
                    OP_LDA: begin
                        word       = CW_MEM_EN | CW_A_LOAD;
                        last_early = 1'b1;
                    end
                    OP_ADD, OP_SUB:
                        word = CW_MEM_EN | CW_B_LOAD;
                    OP_STA: begin
                        word       = CW_A_EN | CW_MEM_WE;
                        last_early = 1'b1;
                    end
                    default: last_early = 1'b1;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_ADD: word = CW_ADDER_EN | CW_A_LOAD | CW_FLAGS_LOAD;
                    OP_SUB: word = CW_ADDER_SUB | CW_ADDER_EN | CW_A_LOAD | CW_FLAGS_LOAD;
                    default: word = '0;
                endcase
                last_early = 1'b1;
            end
            default: last_early = 1'b1;
        endcase
    end

    // Without early end every instruction runs to T5, except HLT which
    // still terminates (and freezes) at T3.
    assign last = (EARLY_END != 0) ? last_early : ((state == T5) || is_hlt);

    always_comb begin
        out        = '0;
        instr_done = 1'b0;
        if (!rst) begin
            if (halt_q) begin
                out = CW_HLT;
            end else if (adv) begin
                out        = word;
                instr_done = last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= T0;
            halt_q <= 1'b0;
            step_q <= 1'b0;
        end else begin
            step_q <= step;
            if (adv) begin
                if (is_hlt)
                    halt_q <= 1'b1;
                else if (last)
                    state <= T0;
                else
                    state <= tstate_t'(state + 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_sap_sequencer.sv
module tb_sap_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        step;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] out;
    logic [2:0]  stage;
    logic        halted;
    logic        instr_done;
    logic [15:0] out2;
    logic [2:0]  stage2;
    logic        halted2;
    logic        instr_done2;

    int total;
    int bad;

    sap_sequencer #(.EARLY_END(1)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z), .out(out), .stage(stage),
        .halted(halted), .instr_done(instr_done)
    );

    sap_sequencer #(.EARLY_END(0)) dut_full (
        .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z), .out(out2), .stage(stage2),
        .halted(halted2), .instr_done(instr_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 unit after that, well away from the next edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    logic [15:0] add_words [6];
    logic [15:0] ldi_full  [6];

    initial begin
        total = 0;
        bad   = 0;
        add_words[0] = 16'h2800; add_words[1] = 16'h4000; add_words[2] = 16'h0500;
        add_words[3] = 16'h0880; add_words[4] = 16'h0410; add_words[5] = 16'h0046;
        ldi_full[0]  = 16'h2800; ldi_full[1]  = 16'h4000; ldi_full[2]  = 16'h0500;
        ldi_full[3]  = 16'h00C0; ldi_full[4]  = 16'h0000; ldi_full[5]  = 16'h0000;

        rst = 1'b1; run = 1'b1; step = 1'b0; opcode = 4'd1; flag_c = 1'b0; flag_z = 1'b0;
        tick(1);
        settle();
        chk("rst_out", out, 16'h0000);
        chk("rst_done", {15'd0, instr_done}, 16'd0);
        chk("rst_stage", {13'd0, stage}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);

        // ADD full sequence
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk($sformatf("add_t%0d_out", i), out, add_words[i]);
            chk($sformatf("add_t%0d_stage", i), {13'd0, stage}, 16'(i));
            chk($sformatf("add_t%0d_done", i), {15'd0, instr_done}, (i == 5) ? 16'd1 : 16'd0);
            tick(1);
        end
        chk("add_wrap_stage", {13'd0, stage}, 16'd0);

        // SUB T5
        opcode = 4'd2;
        tick(5);
        chk("sub_t5_out", out, 16'h004E);
        chk("sub_t5_done", {15'd0, instr_done}, 16'd1);
        tick(1);
        chk("sub_wrap_stage", {13'd0, stage}, 16'd0);

        // LDA
        opcode = 4'd0;
        tick(4);
        chk("lda_t4_out", out, 16'h0440);
        chk("lda_t4_done", {15'd0, instr_done}, 16'd1);
        tick(1);
        chk("lda_wrap_stage", {13'd0, stage}, 16'd0);

        // STA
        opcode = 4'd3;
        tick(4);
        chk("sta_t4_out", out, 16'h0220);
        chk("sta_t4_done", {15'd0, instr_done}, 16'd1);
        tick(1);

        // LDI
        opcode = 4'd4;
        tick(3);
        chk("ldi_t3_out", out, 16'h00C0);
        chk("ldi_t3_done", {15'd0, instr_done}, 16'd1);
        tick(1);
        chk("ldi_wrap_stage", {13'd0, stage}, 16'd0);

        // JMP, OUT, undefined opcode
        opcode = 4'd5;
        tick(3);
        chk("jmp_t3_out", out, 16'h1080);
        tick(1);
        opcode = 4'd14;
        tick(3);
        chk("out_t3_out", out, 16'h0021);
        chk("out_t3_done", {15'd0, instr_done}, 16'd1);
        tick(1);
        opcode = 4'd9;
        tick(3);
        chk("undef_t3_out", out, 16'h0000);
        chk("undef_t3_done", {15'd0, instr_done}, 16'd1);
        tick(1);
        chk("undef_wrap_stage", {13'd0, stage}, 16'd0);

        // JC taken / not taken
        opcode = 4'd6; flag_c = 1'b1; flag_z = 1'b0;
        tick(3);
        chk("jc1_t3_out", out, 16'h1080);
        chk("jc1_t3_done", {15'd0, instr_done}, 16'd1);
        tick(1);
        chk("jc1_wrap_stage", {13'd0, stage}, 16'd0);
        flag_c = 1'b0; flag_z = 1'b1;
        tick(3);
        chk("jc0_t3_out", out, 16'h0000);
        tick(1);
        chk("jc0_wrap_stage", {13'd0, stage}, 16'd0);

        // JZ taken / not taken
        opcode = 4'd7; flag_z = 1'b1; flag_c = 1'b0;
        tick(3);
        chk("jz1_t3_out", out, 16'h1080);
        tick(1);
        chk("jz1_wrap_stage", {13'd0, stage}, 16'd0);
        flag_z = 1'b0; flag_c = 1'b1;
        tick(3);
        chk("jz0_t3_out", out, 16'h0000);
        chk("jz0_t3_done", {15'd0, instr_done}, 16'd1);
        tick(1);
        chk("jz0_wrap_stage", {13'd0, stage}, 16'd0);

        // Single-step: step held high for 5 cycles advances once
        opcode = 4'd1; run = 1'b0; step = 1'b0;
        tick(1);
        settle();
        chk("ss_idle_out", out, 16'h0000);
        step = 1'b1;
        settle();
        chk("ss_edge_out", out, 16'h2800);
        tick(1);
        chk("ss_held_out", out, 16'h0000);
        chk("ss_after1_stage", {13'd0, stage}, 16'd1);
        tick(4);
        chk("ss_held5_stage", {13'd0, stage}, 16'd1);
        step = 1'b0;
        tick(1);
        for (int p = 0; p < 2; p++) begin
            step = 1'b1; tick(1);
            step = 1'b0; tick(1);
        end
        chk("ss_three_pulses_stage", {13'd0, stage}, 16'd3);

        // Step edge while running is absorbed: exactly one advance
        run = 1'b1; step = 1'b1;
        tick(1);
        chk("run_step_stage", {13'd0, stage}, 16'd4);
        step = 1'b0;
        tick(2);
        chk("run_finish_stage", {13'd0, stage}, 16'd0);

        // HLT
        opcode = 4'd15;
        tick(3);
        chk("hlt_t3_out", out, 16'h8000);
        chk("hlt_t3_done", {15'd0, instr_done}, 16'd1);
        tick(1);
        chk("hlt_halted", {15'd0, halted}, 16'd1);
        chk("hlt_stage", {13'd0, stage}, 16'd3);
        chk("hlt_out_hold", out, 16'h8000);
        chk("hlt_done_low", {15'd0, instr_done}, 16'd0);
        run = 1'b0; step = 1'b1; tick(1);
        step = 1'b0; tick(1);
        run = 1'b1; step = 1'b1; tick(1);
        step = 1'b0;
        settle();
        chk("hlt_frozen_stage", {13'd0, stage}, 16'd3);
        chk("hlt_frozen_halted", {15'd0, halted}, 16'd1);
        chk("hlt_frozen_out", out, 16'h8000);
        rst = 1'b1;
        settle();
        chk("hlt_rst_out", out, 16'h0000);
        tick(1);
        rst = 1'b0; opcode = 4'd1;
        settle();
        chk("post_hlt_stage", {13'd0, stage}, 16'd0);
        chk("post_hlt_halted", {15'd0, halted}, 16'd0);
        chk("post_hlt_out", out, 16'h2800);

        // Reset during SUB T4
        opcode = 4'd2;
        tick(4);
        chk("sub_t4_out", out, 16'h0410);
        rst = 1'b1;
        settle();
        chk("midrst_out", out, 16'h0000);
        chk("midrst_done", {15'd0, instr_done}, 16'd0);
        tick(1);
        rst = 1'b0;
        settle();
        chk("midrst_next_stage", {13'd0, stage}, 16'd0);
        chk("midrst_next_out", out, 16'h2800);

        // EARLY_END=0: LDI runs all six T-states
        rst = 1'b1;
        tick(1);
        rst = 1'b0; opcode = 4'd4;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk($sformatf("full_ldi_t%0d_out", i), out2, ldi_full[i]);
            chk($sformatf("full_ldi_t%0d_stage", i), {13'd0, stage2}, 16'(i));
            chk($sformatf("full_ldi_t%0d_done", i), {15'd0, instr_done2}, (i == 5) ? 16'd1 : 16'd0);
            tick(1);
        end
        chk("full_ldi_wrap_stage", {13'd0, stage2}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
